// File: rtl/pkt_goe.sv
// pkt_goe: packet output engine stage that sits after the packet generator.
// Holds a beat FIFO, a per-packet valid FIFO and a per-packet PHV FIFO, and drains them packet by packet.
// The generic FIFO used for all three queues is defined first in this file.

// pkt_goe_fifo: single-clock FIFO with a show-ahead head word and an occupancy count.
// Latency: a pushed word is visible at o_head on the next cycle; a pop advances the head at the clock edge.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module pkt_goe_fifo #(
  parameter int W  = 8,
  parameter int DL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdat,
  input  logic          i_rd,
  output logic [W-1:0]  o_head,
  output logic [DL:0]   o_cnt,
  output logic          o_empty
);
  localparam int D = 1 << DL;

  logic [W-1:0]  r_mem [D];
  logic [DL-1:0] r_wptr;
  logic [DL-1:0] r_rptr;
  logic [DL:0]   r_cnt;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_cnt == (DL+1)'(D));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_rd && !o_empty;
  // When full, the slot being popped this cycle can take the incoming word.
  assign w_push  = i_wr && (!w_full || w_pop);
  assign o_head  = r_mem[r_rptr];
  assign o_cnt   = r_cnt;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + DL'(1);
      if (w_pop)  r_rptr <= r_rptr + DL'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + (DL+1)'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - (DL+1)'(1);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdat;
  end
endmodule

// pkt_goe: stamps the PHV output port into each metadata beat, drops invalid packets, counts packets.
// Latency: first beat out 2 cycles after the FSM leaves IDLE; 1 beat/cycle with 1 idle cycle between packets.
// Backpressure: in_goe_alf is checked only before a packet starts; out_goe_alf/out_goe_phv_alf throttle upstream.
module pkt_goe #(
  parameter int DATA_DEPTH_LOG = 8,
  parameter int PKT_DEPTH_LOG  = 4,
  parameter int ALF_MARGIN     = 32,
  parameter int PHV_PORT_LSB   = 1016,
  parameter int MD_PORT_LSB    = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_goe_data_wr,
  input  logic [133:0]  in_goe_data,
  input  logic          in_goe_valid_wr,
  input  logic          in_goe_valid,
  output logic          out_goe_alf,
  input  logic [1023:0] in_goe_phv,
  input  logic          in_goe_phv_wr,
  output logic          out_goe_phv_alf,
  output logic [133:0]  out_goe_data,
  output logic          out_goe_data_wr,
  output logic          out_goe_valid_wr,
  output logic          out_goe_valid,
  input  logic          in_goe_alf,
  output logic [31:0]   out_goe_pkt_cnt,
  output logic [31:0]   out_goe_drop_cnt
);
  localparam int DW     = 134;
  localparam int PW     = 1024;
  localparam int DDEPTH = 1 << DATA_DEPTH_LOG;
  localparam int PDEPTH = 1 << PKT_DEPTH_LOG;

  typedef enum logic [1:0] {S_IDLE, S_READ_MD, S_SEND, S_DROP} state_t;

  state_t                r_state;
  state_t                w_nxt;

  logic [DW-1:0]         w_data_head;
  logic [DATA_DEPTH_LOG:0] w_data_cnt;
  logic [DATA_DEPTH_LOG:0] w_data_free;
  logic                  w_data_empty;
  logic [0:0]            w_vld_head;
  logic [PKT_DEPTH_LOG:0] w_vld_cnt;
  logic                  w_vld_empty;
  logic                  w_vld_full;
  logic [PW-1:0]         w_phv_head;
  logic [PKT_DEPTH_LOG:0] w_phv_cnt;
  logic [PKT_DEPTH_LOG:0] w_phv_free;
  logic                  w_phv_empty;
  logic                  w_unused_phv;

  logic                  w_pop_pkt;
  logic                  w_pop_data;
  logic                  w_s1_en;
  logic                  w_s1_md;
  logic                  w_s1_last;
  logic                  w_drop_inc;
  logic                  w_head_tail;
  logic [DW-1:0]         w_md_beat;

  logic                  r_valid;
  logic [7:0]            r_port;
  logic                  r_s1_vld;
  logic                  r_s1_last;
  logic [DW-1:0]         r_s1_dat;
  logic [DW-1:0]         r_out_dat;
  logic                  r_out_wr;
  logic                  r_out_eop;
  logic [31:0]           r_pkt_cnt;
  logic [31:0]           r_drop_cnt;
  logic                  r_alf;

  pkt_goe_fifo #(.W(DW), .DL(DATA_DEPTH_LOG)) u_data_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (in_goe_data_wr),
    .i_wdat  (in_goe_data),
    .i_rd    (w_pop_data),
    .o_head  (w_data_head),
    .o_cnt   (w_data_cnt),
    .o_empty (w_data_empty)
  );

  pkt_goe_fifo #(.W(1), .DL(PKT_DEPTH_LOG)) u_vld_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (in_goe_valid_wr),
    .i_wdat  (in_goe_valid),
    .i_rd    (w_pop_pkt),
    .o_head  (w_vld_head),
    .o_cnt   (w_vld_cnt),
    .o_empty (w_vld_empty)
  );

  pkt_goe_fifo #(.W(PW), .DL(PKT_DEPTH_LOG)) u_phv_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (in_goe_phv_wr),
    .i_wdat  (in_goe_phv),
    .i_rd    (w_pop_pkt),
    .o_head  (w_phv_head),
    .o_cnt   (w_phv_cnt),
    .o_empty (w_phv_empty)
  );

  assign w_data_free     = (DATA_DEPTH_LOG+1)'(DDEPTH) - w_data_cnt;
  assign w_vld_full      = (w_vld_cnt == (PKT_DEPTH_LOG+1)'(PDEPTH));
  assign w_phv_free      = (PKT_DEPTH_LOG+1)'(PDEPTH) - w_phv_cnt;
  assign out_goe_phv_alf = (w_phv_free <= (PKT_DEPTH_LOG+1)'(2));
  assign w_head_tail     = (w_data_head[133:132] == 2'b10);
  // Only the port byte of the PHV is consumed here; the rest passes through unused.
  assign w_unused_phv    = ^(w_phv_head & ~(PW'(8'hFF) << PHV_PORT_LSB));

  // Metadata beat with the PHV-selected output port written in.
  always_comb begin
    w_md_beat = w_data_head;
    w_md_beat[MD_PORT_LSB +: 8] = r_port;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // FSM next state and per-cycle pop/emit controls.
  always_comb begin
    w_nxt      = r_state;
    w_pop_pkt  = 1'b0;
    w_pop_data = 1'b0;
    w_s1_en    = 1'b0;
    w_s1_md    = 1'b0;
    w_s1_last  = 1'b0;
    w_drop_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_vld_empty && !w_phv_empty && !in_goe_alf) begin
          w_pop_pkt = 1'b1;
          w_nxt     = S_READ_MD;
        end
      end
      S_READ_MD: begin
        if (!w_data_empty) begin
          w_pop_data = 1'b1;
          if (r_valid) begin
            w_s1_en = 1'b1;
            w_s1_md = 1'b1;
            w_nxt   = S_SEND;
          end else begin
            w_nxt   = S_DROP;
          end
        end
      end
      S_SEND: begin
        if (!w_data_empty) begin
          w_pop_data = 1'b1;
          w_s1_en    = 1'b1;
          if (w_head_tail) begin
            w_s1_last = 1'b1;
            w_nxt     = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (!w_data_empty) begin
          w_pop_data = 1'b1;
          if (w_head_tail) begin
            w_drop_inc = 1'b1;
            w_nxt      = S_IDLE;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Latch the packet's valid flag and output port when the packet is started.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_port  <= '0;
    end else if (w_pop_pkt) begin
      r_valid <= w_vld_head[0];
      r_port  <= w_phv_head[PHV_PORT_LSB +: 8];
    end
  end

  // First pipeline stage: capture the beat popped this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_dat  <= '0;
    end else begin
      r_s1_vld  <= w_s1_en;
      r_s1_last <= w_s1_last;
      if (w_s1_en) r_s1_dat <= w_s1_md ? w_md_beat : w_data_head;
    end
  end

  // Output registers, statistics and the registered data almost-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_dat  <= '0;
      r_out_wr   <= 1'b0;
      r_out_eop  <= 1'b0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_alf      <= 1'b0;
    end else begin
      r_out_wr  <= r_s1_vld;
      r_out_eop <= r_s1_vld && r_s1_last;
      if (r_s1_vld) r_out_dat <= r_s1_dat;
      if (r_s1_vld && r_s1_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 32'd1;
      r_alf <= (w_data_free < (DATA_DEPTH_LOG+1)'(ALF_MARGIN)) || w_vld_full;
    end
  end

  assign out_goe_data     = r_out_dat;
  assign out_goe_data_wr  = r_out_wr;
  assign out_goe_valid_wr = r_out_eop;
  assign out_goe_valid    = r_out_eop;
  assign out_goe_pkt_cnt  = r_pkt_cnt;
  assign out_goe_drop_cnt = r_drop_cnt;
  assign out_goe_alf      = r_alf;
endmodule

// File: tb/tb_pkt_goe.sv
// tb_pkt_goe: directed bench for pkt_goe with a packet table, an output scoreboard and hand-written corner sequences.
// Inputs are driven 1 ns after the rising edge; the output monitor samples on the falling edge.
// Expected beats are built from the stimulus; port stamping on the head beat is applied by the bench model.
module tb_pkt_goe;
  logic          clk;
  logic          rst;
  logic          in_goe_data_wr;
  logic [133:0]  in_goe_data;
  logic          in_goe_valid_wr;
  logic          in_goe_valid;
  logic          out_goe_alf;
  logic [1023:0] in_goe_phv;
  logic          in_goe_phv_wr;
  logic          out_goe_phv_alf;
  logic [133:0]  out_goe_data;
  logic          out_goe_data_wr;
  logic          out_goe_valid_wr;
  logic          out_goe_valid;
  logic          in_goe_alf;
  logic [31:0]   out_goe_pkt_cnt;
  logic [31:0]   out_goe_drop_cnt;

  pkt_goe dut (
    .clk              (clk),
    .rst              (rst),
    .in_goe_data_wr   (in_goe_data_wr),
    .in_goe_data      (in_goe_data),
    .in_goe_valid_wr  (in_goe_valid_wr),
    .in_goe_valid     (in_goe_valid),
    .out_goe_alf      (out_goe_alf),
    .in_goe_phv       (in_goe_phv),
    .in_goe_phv_wr    (in_goe_phv_wr),
    .out_goe_phv_alf  (out_goe_phv_alf),
    .out_goe_data     (out_goe_data),
    .out_goe_data_wr  (out_goe_data_wr),
    .out_goe_valid_wr (out_goe_valid_wr),
    .out_goe_valid    (out_goe_valid),
    .in_goe_alf       (in_goe_alf),
    .out_goe_pkt_cnt  (out_goe_pkt_cnt),
    .out_goe_drop_cnt (out_goe_drop_cnt)
  );

  typedef struct {
    logic [133:0] dat;
    bit           last;
  } exp_t;

  typedef struct {
    int         n;
    bit         vld;
    logic [7:0] port;
    int         exp_pkt;
    int         exp_drop;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   out_cyc[$];
  int   n_vec;
  int   n_err;
  int   n_out;
  int   cyc;
  int   exp_pkt;
  int   exp_drop;
  int   gap_off[7] = '{0, 1, 2, 4, 5, 6, 7};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output scoreboard: every emitted beat must match the next expected beat.
  always @(negedge clk) begin
    if (out_goe_data_wr === 1'b1) begin
      n_out++;
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got beat 0x%0h, expected no output", out_goe_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", out_goe_data, mon_e.dat);
        chk("beat_eop", {out_goe_valid_wr, out_goe_valid}, mon_e.last ? 2'b11 : 2'b00);
      end
    end else if (out_goe_valid_wr === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL eop_without_beat: got valid_wr=1, expected 0");
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [133:0] mk_beat(input int pid, input int b, input int n);
    logic [1:0] fl;
    logic [3:0] bi;
    fl = (b == 0) ? 2'b01 : ((b == n - 1) ? 2'b10 : 2'b11);
    bi = (b == n - 1) ? 4'(pid) : 4'h0;
    return {fl, bi, 8'hAA, 8'(pid), 16'(b), 32'(pid * 131 + b), 64'hDEAD_BEEF_0123_4567};
  endfunction

  task automatic push_exp(input logic [133:0] d, input bit head, input bit last, input logic [7:0] port);
    exp_t e;
    e.dat = d;
    if (head) e.dat[127:120] = port;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [133:0] d, input bit dw, input bit vw, input bit v,
                    input bit pw, input logic [7:0] port);
    in_goe_data     = d;
    in_goe_data_wr  = dw;
    in_goe_valid_wr = vw;
    in_goe_valid    = v;
    in_goe_phv_wr   = pw;
    in_goe_phv      = {port, {127{8'h5A}}};
    tick(1);
    in_goe_data_wr  = 1'b0;
    in_goe_valid_wr = 1'b0;
    in_goe_phv_wr   = 1'b0;
  endtask

  // Writes a packet; valid and PHV go with the tail beat.
  task automatic send_pkt(input int pid, input int n, input bit vld, input logic [7:0] port);
    logic [133:0] d;
    for (int b = 0; b < n; b++) begin
      d = mk_beat(pid, b, n);
      if (vld) push_exp(d, b == 0, b == n - 1, port);
      wr(d, 1'b1, b == n - 1, vld, b == n - 1, port);
    end
    if (vld) exp_pkt++;
    else     exp_drop++;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      tick(1);
      k++;
    end
    chk("drain_done", exp_q.size() == 0, 1);
    tick(12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t         tv[5];
    logic [133:0] d;
    int           base;
    int           total;
    int           nb;
    int           valid_cyc;
    int           k;

    tv[0] = '{4, 1'b1, 8'h05, 1, 0};
    tv[1] = '{3, 1'b0, 8'h33, 1, 1};
    tv[2] = '{2, 1'b1, 8'h7E, 2, 1};
    tv[3] = '{6, 1'b0, 8'h11, 2, 2};
    tv[4] = '{5, 1'b1, 8'hFF, 3, 2};

    rst = 1'b1;
    in_goe_data_wr = 1'b0;
    in_goe_data = '0;
    in_goe_valid_wr = 1'b0;
    in_goe_valid = 1'b0;
    in_goe_phv_wr = 1'b0;
    in_goe_phv = '0;
    in_goe_alf = 1'b0;
    exp_pkt = 0;
    exp_drop = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_wr", out_goe_data_wr, 0);
    chk("rst_valid_wr", out_goe_valid_wr, 0);
    chk("rst_valid", out_goe_valid, 0);
    chk("rst_data", out_goe_data, 0);
    chk("rst_pkt_cnt", out_goe_pkt_cnt, 0);
    chk("rst_drop_cnt", out_goe_drop_cnt, 0);
    chk("rst_alf", out_goe_alf, 0);
    chk("rst_phv_alf", out_goe_phv_alf, 0);
    rst = 1'b0;
    tick(2);

    // Forward/drop table.
    for (int i = 0; i < 5; i++) begin
      send_pkt(i + 1, tv[i].n, tv[i].vld, tv[i].port);
      wait_drain(100);
      chk("tbl_pkt_cnt", out_goe_pkt_cnt, tv[i].exp_pkt);
      chk("tbl_drop_cnt", out_goe_drop_cnt, tv[i].exp_drop);
    end

    // Backpressure before start, then mid-packet assertion must not stall.
    in_goe_alf = 1'b1;
    base = n_out;
    send_pkt(20, 3, 1'b1, 8'h21);
    send_pkt(21, 4, 1'b1, 8'h22);
    tick(10);
    chk("bp_hold", n_out - base, 0);
    out_cyc.delete();
    in_goe_alf = 1'b0;
    k = 0;
    while ((n_out - base) < 4 && k < 60) begin
      tick(1);
      k++;
    end
    in_goe_alf = 1'b1;
    wait_drain(60);
    in_goe_alf = 1'b0;
    chk("bp_nbeats", out_cyc.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < out_cyc.size()) chk("bp_spacing", out_cyc[i] - out_cyc[0], gap_off[i]);
    end
    chk("bp_pkt_cnt", out_goe_pkt_cnt, exp_pkt);

    // Fill the data FIFO past the almost-full threshold, then drain.
    total = 0;
    for (int p = 0; p < 14; p++) begin
      nb = (p == 13) ? 17 : 16;
      for (int b = 0; b < nb; b++) begin
        d = mk_beat(100 + p, b, nb);
        push_exp(d, b == 0, b == nb - 1, 8'(8'h40 + p));
        wr(d, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        total++;
        if (total == 224) begin
          tick(2);
          chk("alf_at_224", out_goe_alf, 0);
        end
        if (total == 225) begin
          chk("alf_lag", out_goe_alf, 0);
          tick(1);
          chk("alf_at_225", out_goe_alf, 1);
        end
      end
    end
    base = n_out;
    for (int p = 0; p < 14; p++) begin
      wr('0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h40 + p));
      if (p == 12) chk("phv_alf_3free", out_goe_phv_alf, 0);
      if (p == 13) chk("phv_alf_2free", out_goe_phv_alf, 1);
    end
    tick(4);
    chk("no_out_without_valid", n_out - base, 0);
    for (int p = 0; p < 14; p++) wr('0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    exp_pkt += 14;
    wait_drain(800);
    chk("alf_cleared", out_goe_alf, 0);
    chk("phv_alf_cleared", out_goe_phv_alf, 0);
    chk("fill_pkt_cnt", out_goe_pkt_cnt, exp_pkt);

    // Reset with a complete packet queued and a partial packet in flight.
    in_goe_alf = 1'b1;
    send_pkt(30, 3, 1'b1, 8'h31);
    wr(mk_beat(31, 0, 5), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    wr(mk_beat(31, 1, 5), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    wr(mk_beat(31, 2, 5), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    in_goe_alf = 1'b0;
    chk("rstmid_data_wr", out_goe_data_wr, 0);
    chk("rstmid_pkt_cnt", out_goe_pkt_cnt, 0);
    chk("rstmid_drop_cnt", out_goe_drop_cnt, 0);
    chk("rstmid_alf", out_goe_alf, 0);
    base = n_out;
    tick(10);
    chk("rstmid_no_out", n_out - base, 0);
    send_pkt(32, 4, 1'b1, 8'h3C);
    wait_drain(60);
    chk("rstmid_pkt_cnt_after", out_goe_pkt_cnt, 1);
    chk("rstmid_drop_cnt_after", out_goe_drop_cnt, 0);

    // PHV arrives 10 cycles ahead of the packet's valid.
    base = n_out;
    out_cyc.delete();
    wr('0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h9C);
    tick(7);
    for (int b = 0; b < 3; b++) begin
      d = mk_beat(40, b, 3);
      push_exp(d, b == 0, b == 2, 8'h9C);
      if (b == 2) chk("phv_early_no_out", n_out - base, 0);
      wr(d, 1'b1, b == 2, 1'b1, 1'b0, 8'h00);
    end
    valid_cyc = cyc;
    exp_pkt++;
    wait_drain(60);
    chk("phv_early_nbeats", out_cyc.size(), 3);
    if (out_cyc.size() > 0) chk("phv_early_latency", out_cyc[0] - valid_cyc, 3);
    chk("phv_early_pkt_cnt", out_goe_pkt_cnt, exp_pkt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
